lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/core_package.sv | 69 ++++++
 rtl/lsu_align.sv | 73 +++++++
 rtl/lsu_stage.sv | 183 ++++++++++++++++++
 tb/tb_lsu_stage.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_package.sv
`default_nettype none
// ============================================================================
//  Module  : core_package
//  Purpose : Shared types and constants for the load/store stage: opcode
//            classes, load/store funct3 encodings, LSU FSM states and the
//            misalignment/legality helper used at op acceptance.
//  Rev     : 1.0  initial release
// ============================================================================
package core_package;

    // Op class presented by the execute stage.
    typedef enum logic [1:0] {
        OPC_ALU   = 2'd0,
        OPC_LOAD  = 2'd1,
        OPC_STORE = 2'd2,
        OPC_OTHER = 2'd3
    } opcode_e;

    // Load funct3 encodings.
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LD  = 3'b011;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_LWU = 3'b110;

    // Store funct3 encodings.
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;
    localparam logic [2:0] c_F3_SD  = 3'b011;

    // LSU FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } lsu_state_e;

    // Returns 1 when a memory op cannot be issued to the bus: either its
    // funct3 is not a legal width for this XLEN, or the address is not a
    // multiple of the access size. Illegal encodings are folded into the
    // misaligned exception so the pipeline has a single fault path.
    function automatic logic lsu_misaligned(
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [2:0] addr_lo,
        input logic       is_64
    );
        logic legal;
        logic aligned;
        if (is_store) begin
            legal = !funct3[2] && (is_64 || (funct3 != c_F3_SD));
        end else begin
            legal = (funct3 != 3'b111) && (is_64 || ((funct3 != c_F3_LD) && (funct3 != c_F3_LWU)));
        end
        case (funct3[1:0])
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = !addr_lo[0];
            2'd2:    aligned = (addr_lo[1:0] == 2'b00);
            default: aligned = (addr_lo == 3'b000);
        endcase
        return !(legal && aligned);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module  : lsu_align
//  Purpose : Purely combinational byte-lane steering for the LSU.
//            Store side: byte enables and lane-replicated write data.
//            Load side : right-shift the bus word to the accessed lane and
//                        sign/zero-extend to XLEN.
//  Ports   : funct3      - width/sign select of the registered op
//            byte_off    - address mod NBYTES
//            store_data  - raw rs2 store data
//            load_word   - full bus read word
//            byte_en     - byte enables (size mask shifted by byte_off)
//            store_lanes - store data replicated across lanes
//            load_data   - extracted, extended load result
//  Rev     : 1.0  initial release
// ============================================================================
module lsu_align
    import core_package::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                   funct3,
    input  logic [$clog2(XLEN/8)-1:0]    byte_off,
    input  logic [XLEN-1:0]              store_data,
    input  logic [XLEN-1:0]              load_word,
    output logic [XLEN/8-1:0]            byte_en,
    output logic [XLEN-1:0]              store_lanes,
    output logic [XLEN-1:0]              load_data
);

    localparam int NBYTES = XLEN / 8;

    logic [NBYTES-1:0] w_size_mask;
    logic [XLEN-1:0]   w_shifted;

    always_comb begin
        case (funct3[1:0])
            2'd0:    w_size_mask = NBYTES'(1);
            2'd1:    w_size_mask = NBYTES'(3);
            2'd2:    w_size_mask = NBYTES'(15);
            default: w_size_mask = '1;
        endcase
    end

    assign byte_en = w_size_mask << byte_off;

    // Replicating the datum over every lane of its size places it on the
    // enabled lanes for any aligned offset without a variable shifter.
    always_comb begin
        case (funct3[1:0])
            2'd0:    store_lanes = {NBYTES{store_data[7:0]}};
            2'd1:    store_lanes = {(NBYTES/2){store_data[15:0]}};
            2'd2:    store_lanes = {(NBYTES/4){store_data[31:0]}};
            default: store_lanes = store_data;
        endcase
    end

    assign w_shifted = load_word >> {byte_off, 3'b000};

    always_comb begin
        case (funct3)
            c_F3_LB:  load_data = XLEN'(signed'(w_shifted[7:0]));
            c_F3_LH:  load_data = XLEN'(signed'(w_shifted[15:0]));
            c_F3_LW:  load_data = XLEN'(signed'(w_shifted[31:0]));
            c_F3_LBU: load_data = XLEN'(w_shifted[7:0]);
            c_F3_LHU: load_data = XLEN'(w_shifted[15:0]);
            c_F3_LWU: load_data = XLEN'(w_shifted[31:0]);
            default:  load_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
//  Module  : lsu_stage
//  Purpose : Load/store pipeline stage between execute and writeback.
//            Non-memory ops pass through with one cycle of latency;
//            misaligned/illegal memory ops return an exception result
//            without touching the bus; aligned loads/stores issue one bus
//            request (held until grant) and, for loads, wait for rvalid.
//  Ports   : clk, reset                      - clock, sync active-high reset
//            in_valid_i/in_ready_o           - op handshake from execute
//            opcode_i, funct3_i, addr_i,
//            ex_data_i, rs2_data_i, rd_i     - op payload
//            mem_req_o/mem_gnt_i, mem_we_o,
//            mem_addr_o, mem_be_o,
//            mem_wdata_o                     - bus request channel
//            mem_rvalid_i, mem_rdata_i       - bus read response
//            out_valid_o/out_ready_i, data_o,
//            rd_o, misalign_o                - result to writeback
//  Rev     : 1.0  initial release
// ============================================================================
module lsu_stage
    import core_package::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  opcode_e             opcode_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     ex_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic [4:0]          rd_i,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic                mem_we_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     data_o,
    output logic [4:0]          rd_o,
    output logic                misalign_o
);

    localparam int NBYTES  = XLEN / 8;
    localparam int c_OFF_W = $clog2(NBYTES);

    lsu_state_e          r_state;
    lsu_state_e          w_state_next;
    opcode_e             r_opcode;
    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_rs2;
    logic [XLEN-1:0]     r_data;
    logic [4:0]          r_rd;
    logic                r_misalign;

    logic                w_accept;
    logic                w_in_is_mem;
    logic                w_in_misaligned;
    logic [NBYTES-1:0]   w_be;
    logic [XLEN-1:0]     w_store_lanes;
    logic [XLEN-1:0]     w_load_data;

    assign w_in_is_mem     = (opcode_i == OPC_LOAD) || (opcode_i == OPC_STORE);
    assign w_in_misaligned = lsu_misaligned(opcode_i == OPC_STORE, funct3_i, addr_i[2:0], XLEN == 64);
    assign w_accept        = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready_o   = 1'b0;
        mem_req_o    = 1'b0;
        out_valid_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    w_state_next = (r_opcode == OPC_STORE) ? ST_HOLD : ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid_i) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // A new op overrides the drain-to-IDLE so HOLD can chain ops
        // back to back without a bubble.
        if (in_valid_i && in_ready_o) begin
            w_state_next = (!w_in_is_mem || w_in_misaligned) ? ST_HOLD : ST_REQ;
        end
    end

    // ------------------------------------------------------------------
    // Op and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode   <= OPC_ALU;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_rs2      <= '0;
            r_data     <= '0;
            r_rd       <= 5'd0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_opcode <= opcode_i;
            r_funct3 <= funct3_i;
            r_addr   <= addr_i;
            r_rs2    <= rs2_data_i;
            r_rd     <= rd_i;
            if (!w_in_is_mem) begin
                r_data     <= ex_data_i;
                r_misalign <= 1'b0;
            end else if (w_in_misaligned) begin
                // Faulting address is reported as the result.
                r_data     <= addr_i;
                r_misalign <= 1'b1;
            end else begin
                // Stores have no result; loads overwrite on rvalid.
                r_data     <= '0;
                r_misalign <= 1'b0;
            end
        end else if ((r_state == ST_RESP) && mem_rvalid_i) begin
            r_data <= w_load_data;
        end
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3      (r_funct3),
        .byte_off    (r_addr[c_OFF_W-1:0]),
        .store_data  (r_rs2),
        .load_word   (mem_rdata_i),
        .byte_en     (w_be),
        .store_lanes (w_store_lanes),
        .load_data   (w_load_data)
    );

    // Address/data are driven straight from the op registers, which do not
    // change while in REQ, so they stay stable until the grant.
    assign mem_addr_o  = {r_addr[XLEN-1:c_OFF_W], {c_OFF_W{1'b0}}};
    assign mem_wdata_o = w_store_lanes;
    assign mem_we_o    = (r_state == ST_REQ) && (r_opcode == OPC_STORE);
    assign mem_be_o    = (r_state == ST_REQ) ? w_be : '0;

    assign data_o      = r_data;
    assign rd_o        = r_rd;
    assign misalign_o  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lsu_stage
//  Purpose : Self-checking bench for lsu_stage. Directed scenarios with
//            literal expectations, then randomized traffic compared against
//            a transaction-level model (expected request and result FIFOs).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_lsu_stage;
    import core_package::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // ---------------- XLEN = 32 instance ----------------
    logic        in_valid_i, in_ready_o;
    opcode_e     opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, ex_data_i, rs2_data_i;
    logic [4:0]  rd_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] data_o;
    logic [4:0]  rd_o;
    logic        misalign_o;

    lsu_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .addr_i(addr_i),
        .ex_data_i(ex_data_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .rd_o(rd_o), .misalign_o(misalign_o)
    );

    // ---------------- XLEN = 64 instance ----------------
    logic        d_in_valid, d_in_ready;
    opcode_e     d_opcode;
    logic [2:0]  d_funct3;
    logic [63:0] d_addr, d_ex_data, d_rs2;
    logic [4:0]  d_rd_in;
    logic        d_req, d_gnt, d_we;
    logic [63:0] d_maddr, d_wdata;
    logic [7:0]  d_be;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_out_valid, d_out_ready;
    logic [63:0] d_data;
    logic [4:0]  d_rd;
    logic        d_mis;

    lsu_stage #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid_i(d_in_valid), .in_ready_o(d_in_ready),
        .opcode_i(d_opcode), .funct3_i(d_funct3), .addr_i(d_addr),
        .ex_data_i(d_ex_data), .rs2_data_i(d_rs2), .rd_i(d_rd_in),
        .mem_req_o(d_req), .mem_gnt_i(d_gnt), .mem_we_o(d_we),
        .mem_addr_o(d_maddr), .mem_be_o(d_be), .mem_wdata_o(d_wdata),
        .mem_rvalid_i(d_rvalid), .mem_rdata_i(d_rdata),
        .out_valid_o(d_out_valid), .out_ready_i(d_out_ready),
        .data_o(d_data), .rd_o(d_rd), .misalign_o(d_mis)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Read-only backing memory, indexed by addr[7:2].
    logic [31:0] mem [64];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        mis;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] lmask;
        logic [31:0] lanes;
        logic [31:0] word;
        logic        is_load;
    } req_t;

    res_t res_q[$];
    req_t req_q[$];

    // Model: legality and alignment from the op's own width rules.
    function automatic logic exp_misaligned(input logic is_store, input logic [2:0] f3, input logic [31:0] a);
        int  size;
        logic legal;
        size = 1 << f3[1:0];
        if (is_store) legal = (f3 inside {3'd0, 3'd1, 3'd2});
        else          legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((int'(a[3:0]) % size) != 0);
    endfunction

    // Model: value a load returns, by plain arithmetic on the bus word.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        int          off, nb;
        logic [63:0] v, mask;
        off  = int'(a[1:0]);
        nb   = 1 << f3[1:0];
        v    = {32'h0, word} >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- monitor / model / responder ----------------
    logic        auto_mode = 1'b0;
    logic        gen_ops   = 1'b0;
    logic        next_rvalid = 1'b0;
    logic [31:0] next_rdata  = 32'h0;
    logic        m_pending   = 1'b0;
    int          m_delay     = 0;
    logic [31:0] m_word      = 32'h0;

    always @(negedge clk) begin : monitor
        logic  granted_load;
        req_t  rq;
        res_t  rs;
        int    off, nb;
        granted_load = 1'b0;
        if (reset) begin
            res_q.delete();
            req_q.delete();
            m_pending   = 1'b0;
            next_rvalid = 1'b0;
        end else begin
            if (out_valid_o) begin
                if (res_q.size() == 0) begin
                    chk("out_valid_without_op", {63'h0, out_valid_o}, 64'h0);
                end else begin
                    chk("data_o", {32'h0, data_o}, {32'h0, res_q[0].data});
                    chk("rd_o", {59'h0, rd_o}, {59'h0, res_q[0].rd});
                    chk("misalign_o", {63'h0, misalign_o}, {63'h0, res_q[0].mis});
                    if (out_ready_i) void'(res_q.pop_front());
                end
            end
            if (mem_req_o) begin
                if (req_q.size() == 0) begin
                    chk("mem_req_without_op", {63'h0, mem_req_o}, 64'h0);
                end else begin
                    chk("mem_addr_o", {32'h0, mem_addr_o}, {32'h0, req_q[0].addr});
                    chk("mem_we_o", {63'h0, mem_we_o}, {63'h0, req_q[0].we});
                    chk("mem_be_o", {60'h0, mem_be_o}, {60'h0, req_q[0].be});
                    if (req_q[0].we)
                        chk("mem_wdata_o", {32'h0, mem_wdata_o & req_q[0].lmask}, {32'h0, req_q[0].lanes});
                    if (mem_gnt_i) begin
                        rq = req_q.pop_front();
                        if (rq.is_load) begin
                            granted_load = 1'b1;
                            m_pending    = 1'b1;
                            m_delay      = $urandom_range(0, 3);
                            m_word       = rq.word;
                        end
                    end
                end
            end
            // Responder decision for the next cycle; rvalid outside an
            // outstanding load is random noise that must be ignored.
            next_rvalid = 1'b0;
            next_rdata  = $urandom;
            if (!granted_load) begin
                if (m_pending) begin
                    if (m_delay == 0) begin
                        next_rvalid = 1'b1;
                        next_rdata  = m_word;
                        m_pending   = 1'b0;
                    end else begin
                        m_delay--;
                    end
                end else begin
                    next_rvalid = ($urandom_range(0, 9) == 0);
                end
            end
            if (in_valid_i && in_ready_o) begin
                rs.rd  = rd_i;
                rs.mis = 1'b0;
                if (opcode_i != OPC_LOAD && opcode_i != OPC_STORE) begin
                    rs.data = ex_data_i;
                end else if (exp_misaligned(opcode_i == OPC_STORE, funct3_i, addr_i)) begin
                    rs.data = addr_i;
                    rs.mis  = 1'b1;
                end else begin
                    off        = int'(addr_i[1:0]);
                    nb         = 1 << funct3_i[1:0];
                    rq.addr    = addr_i & ~32'h3;
                    rq.we      = (opcode_i == OPC_STORE);
                    rq.is_load = (opcode_i == OPC_LOAD);
                    rq.be      = 4'(((1 << nb) - 1) << off);
                    rq.lmask   = 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (rq.be[b]) rq.lmask[8*b +: 8] = 8'hFF;
                    rq.lanes   = (rs2_data_i << (8 * off)) & rq.lmask;
                    rq.word    = mem[addr_i[7:2]];
                    req_q.push_back(rq);
                    rs.data    = rq.is_load ? exp_load(funct3_i, addr_i, rq.word) : 32'h0;
                end
                res_q.push_back(rs);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        int r, sz;
        logic [7:0] a8;
        @(posedge clk);
        #1;
        if (auto_mode) begin
            mem_rvalid_i = next_rvalid;
            mem_rdata_i  = next_rdata;
            mem_gnt_i    = gen_ops ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready_i  = gen_ops ? ($urandom_range(0, 3) != 0) : 1'b1;
            reset        = gen_ops && ($urandom_range(0, 499) == 0);
            in_valid_i   = gen_ops && ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 10);
            opcode_i   = (r < 3) ? OPC_ALU : (r < 7) ? OPC_LOAD : (r < 10) ? OPC_STORE : OPC_OTHER;
            funct3_i   = (opcode_i == OPC_STORE && $urandom_range(0, 5) != 0) ? 3'($urandom_range(0, 3))
                                                                             : 3'($urandom_range(0, 7));
            sz         = 1 << funct3_i[1:0];
            a8         = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a8 = a8 & ~8'(sz - 1);
            addr_i     = ($urandom & 32'hFFFF_FF00) | {24'h0, a8};
            ex_data_i  = $urandom;
            rs2_data_i = $urandom;
            rd_i       = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic set_op(input opcode_e op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] ex, input logic [31:0] rs2, input logic [4:0] rd);
        in_valid_i = 1'b1; opcode_i = op; funct3_i = f3; addr_i = a;
        ex_data_i = ex; rs2_data_i = rs2; rd_i = rd;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h80FF_FF00;
        reset = 1'b1;
        in_valid_i = 1'b0; opcode_i = OPC_ALU; funct3_i = 3'd0; addr_i = '0;
        ex_data_i = '0; rs2_data_i = '0; rd_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; out_ready_i = 1'b0;
        d_in_valid = 1'b0; d_opcode = OPC_ALU; d_funct3 = 3'd0; d_addr = '0;
        d_ex_data = '0; d_rs2 = '0; d_rd_in = '0;
        d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = '0; d_out_ready = 1'b0;
        tick(); tick();

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {63'h0, out_valid_o}, 64'h0);
        chk("rst_mem_req",   {63'h0, mem_req_o}, 64'h0);
        chk("rst_mem_be",    {60'h0, mem_be_o}, 64'h0);
        chk("rst_mem_we",    {63'h0, mem_we_o}, 64'h0);
        chk("rst_data",      {32'h0, data_o}, 64'h0);
        chk("rst_rd",        {59'h0, rd_o}, 64'h0);
        chk("rst_mem_addr",  {32'h0, mem_addr_o}, 64'h0);
        chk("rst_wdata",     {32'h0, mem_wdata_o}, 64'h0);
        chk("rst_misalign",  {63'h0, misalign_o}, 64'h0);
        chk("rst_in_ready",  {63'h0, in_ready_o}, 64'h1);
        tick();
        reset = 1'b0;

        // LB at 0x1003, rdata 0x80FF_FF00
        set_op(OPC_LOAD, c_F3_LB, 32'h1003, 32'h0, 32'h0, 5'd5);
        tick();
        in_valid_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("lb_req",  {63'h0, mem_req_o}, 64'h1);
        chk("lb_addr", {32'h0, mem_addr_o}, 64'h1000);
        chk("lb_be",   {60'h0, mem_be_o}, 64'h8);
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_FF00;
        @(negedge clk);
        chk("lb_wait_valid", {63'h0, out_valid_o}, 64'h0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("lb_out_valid", {63'h0, out_valid_o}, 64'h1);
        chk("lb_data", {32'h0, data_o}, 64'hFFFF_FF80);
        chk("lb_rd", {59'h0, rd_o}, 64'd5);
        out_ready_i = 1'b1;
        tick();

        // SH at 0x2002, grant delayed 3 cycles
        out_ready_i = 1'b0;
        set_op(OPC_STORE, c_F3_SH, 32'h2002, 32'h0, 32'h0000_BEEF, 5'd0);
        tick();
        in_valid_i = 1'b0; mem_gnt_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_gnt_i = 1'b1;
            @(negedge clk);
            chk("sh_req",   {63'h0, mem_req_o}, 64'h1);
            chk("sh_addr",  {32'h0, mem_addr_o}, 64'h2000);
            chk("sh_be",    {60'h0, mem_be_o}, 64'hC);
            chk("sh_we",    {63'h0, mem_we_o}, 64'h1);
            chk("sh_wdata", {48'h0, mem_wdata_o[31:16]}, 64'hBEEF);
            tick();
        end
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk("sh_out_valid", {63'h0, out_valid_o}, 64'h1);
        chk("sh_misalign", {63'h0, misalign_o}, 64'h0);
        out_ready_i = 1'b1;
        tick();

        // LW at 0x6: misaligned, no bus request
        out_ready_i = 1'b0;
        set_op(OPC_LOAD, c_F3_LW, 32'h6, 32'h0, 32'h0, 5'd7);
        tick();
        in_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("lw_mis_req", {63'h0, mem_req_o}, 64'h0);
            chk("lw_mis_valid", {63'h0, out_valid_o}, 64'h1);
            chk("lw_mis_flag", {63'h0, misalign_o}, 64'h1);
            chk("lw_mis_data", {32'h0, data_o}, 64'h6);
            tick();
        end
        out_ready_i = 1'b1;
        tick();

        // Back-to-back ALU ops, then writeback stall
        set_op(OPC_ALU, 3'd0, 32'h0, 32'hA1A1_0001, 32'h0, 5'd1);
        tick();
        set_op(OPC_ALU, 3'd0, 32'h0, 32'hA2A2_0002, 32'h0, 5'd2);
        @(negedge clk);
        chk("b2b_1_data", {32'h0, data_o}, 64'hA1A1_0001);
        chk("b2b_1_ready", {63'h0, in_ready_o}, 64'h1);
        tick();
        set_op(OPC_ALU, 3'd0, 32'h0, 32'hA3A3_0003, 32'h0, 5'd3);
        @(negedge clk);
        chk("b2b_2_data", {32'h0, data_o}, 64'hA2A2_0002);
        chk("b2b_2_valid", {63'h0, out_valid_o}, 64'h1);
        tick();
        set_op(OPC_ALU, 3'd0, 32'h0, 32'hA4A4_0004, 32'h0, 5'd4);
        out_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_valid", {63'h0, out_valid_o}, 64'h1);
            chk("stall_data", {32'h0, data_o}, 64'hA3A3_0003);
            chk("stall_rd", {59'h0, rd_o}, 64'd3);
            chk("stall_in_ready", {63'h0, in_ready_o}, 64'h0);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_4_data", {32'h0, data_o}, 64'hA4A4_0004);
        tick();

        // Reset during RESP, then a stray rvalid
        set_op(OPC_LOAD, c_F3_LW, 32'h10, 32'h0, 32'h0, 5'd9);
        tick();
        in_valid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        tick();
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_resp_valid", {63'h0, out_valid_o}, 64'h0);
            chk("rst_resp_idle", {63'h0, in_ready_o}, 64'h1);
            chk("rst_resp_req", {63'h0, mem_req_o}, 64'h0);
            tick();
        end

        // XLEN=64: LWU at 0x4
        d_in_valid = 1'b1; d_opcode = OPC_LOAD; d_funct3 = c_F3_LWU; d_addr = 64'h4; d_rd_in = 5'd11;
        tick();
        d_in_valid = 1'b0; d_gnt = 1'b1;
        @(negedge clk);
        chk("x64_req", {63'h0, d_req}, 64'h1);
        chk("x64_addr", d_maddr, 64'h0);
        chk("x64_be", {56'h0, d_be}, 64'hF0);
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 64'hFFFF_FFFF_0000_0000;
        tick();
        d_rvalid = 1'b0; d_out_ready = 1'b1;
        @(negedge clk);
        chk("x64_lwu_valid", {63'h0, d_out_valid}, 64'h1);
        chk("x64_lwu_data", d_data, 64'h0000_0000_FFFF_FFFF);
        tick();
        // XLEN=64: LD at 0x4 is misaligned
        d_in_valid = 1'b1; d_funct3 = c_F3_LD; d_addr = 64'h4;
        tick();
        d_in_valid = 1'b0;
        @(negedge clk);
        chk("x64_ld_mis", {63'h0, d_mis}, 64'h1);
        chk("x64_ld_data", d_data, 64'h4);
        chk("x64_ld_req", {63'h0, d_req}, 64'h0);
        tick();

        // Randomized traffic against the model
        auto_mode = 1'b1;
        gen_ops   = 1'b1;
        for (int c = 0; c < 4000; c++) tick();
        gen_ops = 1'b0;
        for (int c = 0; c < 60; c++) tick();
        chk("drain_results", 64'(res_q.size()), 64'h0);
        chk("drain_requests", 64'(req_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
